// File: rtl/divider_datapath.sv
// Register file and ALU for an iterative restoring unsigned divider.
// Executes the strobes issued by the start/ready controller and reports Co/Comp back to it.
module divider_datapath #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         init,
  input  logic         s,
  input  logic         add_sub,
  input  logic         ldt,
  input  logic         ldr,
  input  logic         cnt_en,
  output logic         Co,
  output logic         Comp,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rem
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N:0]    r;
  logic [N:0]    t;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic [N:0]    alu;

  // One extra bit so a failed trial subtraction shows up as T[N] = 1
  always_comb begin
    alu = r + {1'b0, d};
    if (add_sub)
      alu = r - {1'b0, d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r   <= '0;
      t   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (init) begin
      r   <= '0;
      t   <= '0;
      q   <= A;
      d   <= B;
      cnt <= '0;
    end else begin
      if (ldt)
        t <= alu;
      if (ldr) begin
        if (s) begin
          r    <= t;
          q[0] <= 1'b1;
        end else begin
          r <= {r[N-1:0], q[N-1]};
          q <= {q[N-2:0], 1'b0};
        end
      end
      // Explicit wrap keeps the count correct when N is not a power of two
      if (cnt_en)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign Co   = (cnt == CNT_LAST);
  assign Comp = ~t[N];
  assign Q    = q;
  assign Rem  = r[N-1:0];

endmodule
